// File: rtl/lfsr_prbs_gen.sv
// XNOR Fibonacci LFSR/PRBS source with runtime taps, lock-up detection and period measurement.
// Define LFSR_LOCKUP_RECOVER_EN to auto-recover from the all-ones lock-up state after one cycle.
module lfsr_prbs_gen #(
    parameter int unsigned      WIDTH        = 16,
    parameter logic [WIDTH-1:0] DEFAULT_TAPS = WIDTH'(16'hD008),
    parameter logic [WIDTH-1:0] DEFAULT_SEED = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enable,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_seed,
    input  logic             i_taps_we,
    input  logic [WIDTH-1:0] i_taps,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_lockup,
    output logic             o_period_done,
    output logic [WIDTH-1:0] o_period
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_lfsr;
    logic [WIDTH-1:0] r_ref;
    logic [WIDTH-1:0] r_taps;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_period;
    logic             r_period_done;

    logic             w_fb;
    logic [WIDTH-1:0] w_lfsr_nxt;
    logic             w_all_ones;
    logic             w_valid;
    logic             w_lockup;
    logic             w_recover;
    logic             w_adv;
    logic             w_wrap;
    logic [WIDTH-1:0] w_cnt_inc;

    // XNOR feedback: the all-ones state maps to itself and is the lock-up state.
    assign w_fb       = ~^(r_lfsr & r_taps);
    assign w_lfsr_nxt = {r_lfsr[WIDTH-2:0], w_fb};
    assign w_all_ones = (r_lfsr == {WIDTH{1'b1}});

    // Load and tap writes take the cycle, so no beat is transferred alongside them.
    assign w_adv      = w_valid && i_ready && !i_load && !i_taps_we;
    assign w_wrap     = w_adv && (w_lfsr_nxt == r_ref);
    assign w_cnt_inc  = (r_cnt == {WIDTH{1'b1}}) ? r_cnt : r_cnt + WIDTH'(1);

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and stream control
    always_comb begin
        w_state_nxt = r_state;
        w_valid     = 1'b0;
        w_lockup    = 1'b0;
        w_recover   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_state_nxt = S_IDLE;
            end
            S_RUN: begin
                w_valid = i_enable && !w_all_ones;
                if (w_all_ones) begin
                    w_state_nxt = S_LOCKED;
                end
            end
            S_LOCKED: begin
                w_lockup = 1'b1;
`ifdef LFSR_LOCKUP_RECOVER_EN
                w_recover   = 1'b1;
                w_state_nxt = S_RUN;
`else
                w_state_nxt = S_LOCKED;
`endif
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (i_load) begin
            w_state_nxt = S_RUN;
        end
    end

    // Shift register, reference, tap mask and period counter
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_lfsr        <= DEFAULT_SEED;
            r_ref         <= DEFAULT_SEED;
            r_taps        <= DEFAULT_TAPS;
            r_cnt         <= '0;
            r_period      <= '0;
            r_period_done <= 1'b0;
        end else begin
            r_period_done <= 1'b0;
            if (i_taps_we) begin
                r_taps <= i_taps;
            end
            if (i_load) begin
                r_lfsr <= i_seed;
                r_ref  <= i_seed;
                r_cnt  <= '0;
            end else if (w_recover) begin
                r_lfsr <= '0;
                r_ref  <= '0;
                r_cnt  <= '0;
            end else if (i_taps_we) begin
                r_ref <= r_lfsr;
                r_cnt <= '0;
            end else if (w_adv) begin
                r_lfsr <= w_lfsr_nxt;
                if (w_wrap) begin
                    r_period      <= w_cnt_inc;
                    r_cnt         <= '0;
                    r_period_done <= 1'b1;
                end else begin
                    r_cnt <= w_cnt_inc;
                end
            end
        end
    end

    assign o_valid       = w_valid;
    assign o_data        = r_lfsr;
    assign o_lockup      = w_lockup;
    assign o_period_done = r_period_done;
    assign o_period      = r_period;

endmodule

// File: tb/tb_lfsr_prbs_gen.sv
// Directed bench for lfsr_prbs_gen at WIDTH=4, taps 4'hC; honours LFSR_LOCKUP_RECOVER_EN if defined.
module tb_lfsr_prbs_gen;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_enable;
    logic       i_load;
    logic [3:0] i_seed;
    logic       i_taps_we;
    logic [3:0] i_taps;
    logic       i_ready;
    logic       o_valid;
    logic [3:0] o_data;
    logic       o_lockup;
    logic       o_period_done;
    logic [3:0] o_period;

    int vectors     = 0;
    int miscompares = 0;

    logic [3:0] seq_a [16];
    logic [3:0] seq_b [16];

    lfsr_prbs_gen #(
        .WIDTH       (4),
        .DEFAULT_TAPS(4'hC),
        .DEFAULT_SEED(4'h0)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_enable     (i_enable),
        .i_load       (i_load),
        .i_seed       (i_seed),
        .i_taps_we    (i_taps_we),
        .i_taps       (i_taps),
        .i_ready      (i_ready),
        .o_valid      (o_valid),
        .o_data       (o_data),
        .o_lockup     (o_lockup),
        .o_period_done(o_period_done),
        .o_period     (o_period)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        seq_a = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB, 4'h6,
                  4'hC, 4'h9, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8, 4'h0};
        seq_b = '{4'h6, 4'hC, 4'h9, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8,
                  4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB, 4'h6};

        i_rst = 1'b0; i_enable = 1'b1; i_load = 1'b0; i_seed = 4'h0;
        i_taps_we = 1'b0; i_taps = 4'h0; i_ready = 1'b1;
        tick();
        tick();
        i_rst = 1'b1;
        #1;
        check("rst_valid",  32'(o_valid), 32'd0);
        check("rst_lockup", 32'(o_lockup), 32'd0);
        check("rst_done",   32'(o_period_done), 32'd0);
        check("rst_period", 32'(o_period), 32'd0);
        check("rst_data",   32'(o_data), 32'd0);
        tick();
        check("idle_valid", 32'(o_valid), 32'd0);
        check("idle_data",  32'(o_data), 32'd0);

        // Full period from seed 0, with a 3-cycle stall at 7
        i_load = 1'b1; i_seed = 4'h0;
        tick();
        i_load = 1'b0;
        #1;
        check("load0_data",  32'(o_data), 32'd0);
        check("load0_valid", 32'(o_valid), 32'd1);
        for (int k = 1; k < 16; k++) begin
            tick();
            check($sformatf("seqA_data[%0d]", k), 32'(o_data), 32'(seq_a[k]));
            check($sformatf("seqA_done[%0d]", k), 32'(o_period_done), (k == 15) ? 32'd1 : 32'd0);
            if (k == 15) check("seqA_period", 32'(o_period), 32'd15);
            if (k == 3) begin
                i_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    check("stall_data",  32'(o_data), 32'h7);
                    check("stall_valid", 32'(o_valid), 32'd1);
                    check("stall_done",  32'(o_period_done), 32'd0);
                end
                i_ready = 1'b1;
            end
        end
        tick();
        check("post_data",   32'(o_data), 32'h1);
        check("post_done",   32'(o_period_done), 32'd0);
        check("post_period", 32'(o_period), 32'd15);
        tick();
        check("pre_load_data", 32'(o_data), 32'h3);

        // Load seed 6 while ready: no advance, period restarts from 6
        i_load = 1'b1; i_seed = 4'h6;
        tick();
        i_load = 1'b0;
        check("load6_data", 32'(o_data), 32'h6);
        for (int k = 1; k < 16; k++) begin
            tick();
            check($sformatf("seqB_data[%0d]", k), 32'(o_data), 32'(seq_b[k]));
            check($sformatf("seqB_done[%0d]", k), 32'(o_period_done), (k == 15) ? 32'd1 : 32'd0);
        end
        check("seqB_period", 32'(o_period), 32'd15);
        for (int k = 1; k < 15; k++) begin
            tick();
            check($sformatf("seqB2_data[%0d]", k), 32'(o_data), 32'(seq_b[k]));
        end

        // Reset mid-run at B
        i_rst = 1'b0;
        tick();
        i_rst = 1'b1;
        #1;
        check("mrst_valid",  32'(o_valid), 32'd0);
        check("mrst_period", 32'(o_period), 32'd0);
        check("mrst_data",   32'(o_data), 32'd0);
        check("mrst_done",   32'(o_period_done), 32'd0);
        tick();
        check("mrst_idle_valid", 32'(o_valid), 32'd0);
        check("mrst_idle_data",  32'(o_data), 32'd0);

        // Taps 0: constant feedback 1 runs into lock-up
        i_load = 1'b1; i_seed = 4'h0;
        tick();
        i_load = 1'b0;
        check("t0_load_data", 32'(o_data), 32'd0);
        i_taps_we = 1'b1; i_taps = 4'h0;
        tick();
        i_taps_we = 1'b0;
        check("t0_wr_data",  32'(o_data), 32'd0);
        check("t0_wr_valid", 32'(o_valid), 32'd1);
        tick(); check("t0_d1", 32'(o_data), 32'h1);
        tick(); check("t0_d3", 32'(o_data), 32'h3);
        tick(); check("t0_d7", 32'(o_data), 32'h7);
        tick();
        check("t0_dF",       32'(o_data), 32'hF);
        check("t0_F_valid",  32'(o_valid), 32'd0);
        check("t0_F_lockup", 32'(o_lockup), 32'd0);
        tick();
        check("t0_lk_lockup", 32'(o_lockup), 32'd1);
        check("t0_lk_valid",  32'(o_valid), 32'd0);
        check("t0_lk_data",   32'(o_data), 32'hF);
`ifdef LFSR_LOCKUP_RECOVER_EN
        tick();
        check("t0_rec_lockup", 32'(o_lockup), 32'd0);
        check("t0_rec_data",   32'(o_data), 32'd0);
        check("t0_rec_valid",  32'(o_valid), 32'd1);
`else
        tick();
        tick();
        check("t0_hold_lockup", 32'(o_lockup), 32'd1);
        check("t0_hold_data",   32'(o_data), 32'hF);
        check("t0_hold_valid",  32'(o_valid), 32'd0);
`endif

        // Load seed F together with restoring taps C
        i_load = 1'b1; i_seed = 4'hF; i_taps_we = 1'b1; i_taps = 4'hC;
        tick();
        i_load = 1'b0; i_taps_we = 1'b0;
        check("lF_data",   32'(o_data), 32'hF);
        check("lF_valid",  32'(o_valid), 32'd0);
        check("lF_lockup", 32'(o_lockup), 32'd0);
        tick();
        check("lF_lk_lockup", 32'(o_lockup), 32'd1);
        check("lF_lk_valid",  32'(o_valid), 32'd0);
`ifdef LFSR_LOCKUP_RECOVER_EN
        tick();
        check("lF_rec_lockup", 32'(o_lockup), 32'd0);
        check("lF_rec_data",   32'(o_data), 32'd0);
        check("lF_rec_valid",  32'(o_valid), 32'd1);
`else
        tick();
        check("lF_hold_lockup", 32'(o_lockup), 32'd1);
        check("lF_hold_data",   32'(o_data), 32'hF);
        i_load = 1'b1; i_seed = 4'h0;
        tick();
        i_load = 1'b0;
        check("lk_exit_data",   32'(o_data), 32'd0);
        check("lk_exit_valid",  32'(o_valid), 32'd1);
        check("lk_exit_lockup", 32'(o_lockup), 32'd0);
`endif
        for (int k = 0; k < 4; k++) tick();
        check("tapsC_data", 32'(o_data), 32'hE);

        // Enable low freezes the stream
        i_enable = 1'b0;
        #1;
        check("dis_valid", 32'(o_valid), 32'd0);
        tick();
        tick();
        check("dis_data", 32'(o_data), 32'hE);
        i_enable = 1'b1;
        #1;
        check("en_valid", 32'(o_valid), 32'd1);
        tick();
        check("en_data", 32'(o_data), 32'hD);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
